bcd_operand_entry: RTL

Upstream operand-entry stage for the two-digit BCD adder datapath. Conditions the four raw DE2 pushbuttons with synchronisation, debounce and hold-to-repeat, and maintains two 2-digit BCD operands, one 4-bit counter per digit. The operands feed the BCD adder and the HEX7..HEX4 operand decoders directly. Replaces bare key-clocked digit counters with a single-clock design.

---
 rtl/bcd_entry_pkg.sv | 25 ++
 rtl/bcd_operand_entry_key_conditioner.sv | 108 ++++++++++
 rtl/bcd_operand_entry.sv | 64 ++++++
 3 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared types and helpers for the BCD operand-entry stage.
// Press-FSM states, key index map and the BCD digit step.
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEATING
  } press_st_e;

  localparam int KEY_A_TENS = 3;
  localparam int KEY_A_ONES = 2;
  localparam int KEY_B_TENS = 1;
  localparam int KEY_B_ONES = 0;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Out-of-range codes 10..15 also wrap to 0.
  function automatic logic [3:0] bcd_step(
    input logic [3:0] v
  );
    return (v >= BCD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_operand_entry_key_conditioner.sv
// One pushbutton: 2-flop sync, debounce filter, press/repeat FSM.
// step is a registered one-cycle pulse per accepted press or repeat.
module key_conditioner
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1;
  logic          s2;
  logic          filt;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      filt <= 1'b1;
      dcnt <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (s2 == filt) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        filt <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  press_st_e     state;
  press_st_e     state_n;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_n;
  logic          step_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      step  <= step_n;
    end
  end

  // IDLE is only reachable with filt high, so filt low there is a fresh press.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    step_n  = 1'b0;
    if (filt) begin
      state_n = IDLE;
      rcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = PRESSED;
          rcnt_n  = '0;
          step_n  = 1'b1;
        end
        PRESSED: begin
          if (rcnt == RD_LAST) begin
            state_n = REPEATING;
            rcnt_n  = '0;
            step_n  = 1'b1;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        REPEATING: begin
          if (rcnt == RP_LAST) begin
            rcnt_n = '0;
            step_n = 1'b1;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          rcnt_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Two 2-digit BCD operands driven by four conditioned pushbuttons.
// Digits step independently; clr zeroes both and wins over steps.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] KEY,
  input  logic       clr,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       changed
);

  logic [3:0] step;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_kc (
      .clk  (CLOCK_50),
      .rst_n(resetn),
      .key_n(KEY[k]),
      .step (step[k])
    );
  end

  logic [3:0] a_t;
  logic [3:0] a_o;
  logic [3:0] b_t;
  logic [3:0] b_o;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      a_t     <= '0;
      a_o     <= '0;
      b_t     <= '0;
      b_o     <= '0;
      changed <= 1'b0;
    end else if (clr) begin
      a_t     <= '0;
      a_o     <= '0;
      b_t     <= '0;
      b_o     <= '0;
      changed <= |{a_t, a_o, b_t, b_o};
    end else begin
      changed <= |step;
      if (step[KEY_A_TENS]) a_t <= bcd_step(a_t);
      if (step[KEY_A_ONES]) a_o <= bcd_step(a_o);
      if (step[KEY_B_TENS]) b_t <= bcd_step(b_t);
      if (step[KEY_B_ONES]) b_o <= bcd_step(b_o);
    end
  end

  assign a = {a_t, a_o};
  assign b = {b_t, b_o};

endmodule
